// File: rtl/stream_packet_arbiter.sv
// stream_packet_arbiter
//   Packet-level round-robin arbiter: NUM_PORTS valid/ready/last byte streams
//   share one registered output stream. A granted port keeps the output until
//   its last beat has been forwarded, so packets never interleave.
//   Optional feature macro: STREAM_ARB_PKTCNT_EN adds a 16-bit wrapping
//   pkt_count output counting packets accepted downstream.
module stream_packet_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    localparam int GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_n,
    input  logic [NUM_PORTS-1:0]            sink_valid,
    input  logic [NUM_PORTS-1:0]            sink_last,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] sink_data,
    output logic [NUM_PORTS-1:0]            sink_ready,
    output logic                            source_valid,
    output logic                            source_last,
    output logic [DATA_WIDTH-1:0]           source_data,
    input  logic                            source_ready,
`ifdef STREAM_ARB_PKTCNT_EN
    output logic [15:0]                     pkt_count,
`endif
    output logic [GW-1:0]                   grant_id,
    output logic                            busy
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]            state;
    logic [GW-1:0]         last_grant;
    logic [GW-1:0]         next_grant;
    logic                  any_req;
    logic                  out_free;
    logic                  xfer;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;

    // The output register can take a new beat when empty or draining this cycle.
    assign out_free = !source_valid || source_ready;
    assign xfer     = (state == ST_LOCKED) && sel_valid && out_free;
    assign busy     = (state == ST_LOCKED);

    // Round-robin pick: lowest circular distance from last_grant+1 wins.
    // Scanning from the farthest distance down lets the nearest request overwrite.
    always_comb begin
        next_grant = last_grant;
        any_req    = 1'b0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if ((((int'(last_grant) + k) % NUM_PORTS) == i) && sink_valid[i]) begin
                    next_grant = GW'(i);
                    any_req    = 1'b1;
                end
            end
        end
    end

    // Select the granted port's beat for the output register.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_id == GW'(i)) begin
                sel_valid = sink_valid[i];
                sel_last  = sink_last[i];
                sel_data  = sink_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Only the locked port sees ready; the IDLE arbitration cycle never transfers.
    always_comb begin
        sink_ready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sink_ready[i] = (state == ST_LOCKED) && (grant_id == GW'(i)) && out_free;
        end
    end

    // Arbitration FSM: grant in IDLE, release after the granted last beat.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NUM_PORTS - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_id <= next_grant;
                        state    <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (xfer && sel_last) begin
                        last_grant <= grant_id;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Single-stage output register; holds data/last while stalled downstream.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            source_valid <= 1'b0;
            source_last  <= 1'b0;
            source_data  <= '0;
        end else if (xfer) begin
            source_valid <= 1'b1;
            source_last  <= sel_last;
            source_data  <= sel_data;
        end else if (source_ready) begin
            source_valid <= 1'b0;
        end
    end

`ifdef STREAM_ARB_PKTCNT_EN
    // Count packets whose last beat is accepted downstream; wraps at 16 bits.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pkt_count <= 16'd0;
        end else if (source_valid && source_ready && source_last) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Testbench for stream_packet_arbiter (NUM_PORTS=4, DATA_WIDTH=8).
// Per-port packet sources feed the DUT; every beat loaded is also pushed, in
// the order it must leave the arbiter, onto a scoreboard that is popped when
// the output handshake occurs.
module tb_stream_packet_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [3:0]  sink_valid;
    logic [3:0]  sink_last;
    logic [31:0] sink_data;
    logic [3:0]  sink_ready;
    logic        source_valid;
    logic        source_last;
    logic [7:0]  source_data;
    logic        source_ready;
    logic [1:0]  grant_id;
    logic        busy;
`ifdef STREAM_ARB_PKTCNT_EN
    logic [15:0] pkt_count;
`endif

    stream_packet_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(8)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .sink_valid   (sink_valid),
        .sink_last    (sink_last),
        .sink_data    (sink_data),
        .sink_ready   (sink_ready),
        .source_valid (source_valid),
        .source_last  (source_last),
        .source_data  (source_data),
        .source_ready (source_ready),
`ifdef STREAM_ARB_PKTCNT_EN
        .pkt_count    (pkt_count),
`endif
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int          errors = 0;
    int          checks = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  sb_exp;
    bit          mon_en = 1'b1;
    logic [8:0]  mem [4][64];
    logic [5:0]  head [4];
    logic [5:0]  tail [4];
    logic [3:0]  hold;
    logic [3:0]  taken;

    // Scoreboard: every accepted output beat must match the next expected one.
    always @(negedge sys_clk) begin
        if (mon_en && sys_rst_n && source_valid && source_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra got=%h last=%b exp=none", source_data, source_last);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({source_last, source_data} !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_beat got=%h last=%b exp=%h last=%b",
                             source_data, source_last, sb_exp[7:0], sb_exp[8]);
                end
            end
        end
    end

    task automatic load(input int p, input logic [7:0] d, input logic l, input bit push);
        mem[p][tail[p]] = {l, d};
        tail[p]++;
        if (push) exp_q.push_back({l, d});
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) head[i] = tail[i];
        hold       = '0;
        taken      = '0;
        sink_valid = '0;
        sink_last  = '0;
        sink_data  = '0;
        exp_q.delete();
    endtask

    // Advance one clock: update sources after the edge, sample at the falling edge.
    task automatic step(input logic rdy);
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (taken[i]) head[i]++;
            if ((head[i] != tail[i]) && !hold[i]) begin
                sink_valid[i]       = 1'b1;
                sink_data[i*8 +: 8] = mem[i][head[i]][7:0];
                sink_last[i]        = mem[i][head[i]][8];
            end else begin
                sink_valid[i]       = 1'b0;
                sink_data[i*8 +: 8] = 8'h00;
                sink_last[i]        = 1'b0;
            end
        end
        source_ready = rdy;
        @(negedge sys_clk);
        taken = sink_valid & sink_ready;
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        flush();
        #2 sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin head[i] = '0; tail[i] = '0; end
        hold         = '0;
        taken        = '0;
        source_ready = 1'b1;
        sink_valid   = '1;
        sink_last    = '1;
        sink_data    = '1;
        sys_rst_n    = 1'b1;
        #2 sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        checks++;
        if ({source_valid, source_last, source_data} !== 10'd0) begin
            errors++;
            $display("FAIL reset_source got=%b/%b/%h exp=0/0/00", source_valid, source_last, source_data);
        end
        checks++;
        if (sink_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=0000", sink_ready);
        end
        checks++;
        if ({busy, grant_id} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state got busy=%b grant=%0d exp busy=0 grant=0", busy, grant_id);
        end
        flush();
        sys_rst_n = 1'b1;
        step(1'b1);
        step(1'b1);
        checks++;
        if (busy !== 1'b0 || source_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b valid=%b exp 0/0", busy, source_valid);
        end
    endtask

    task automatic test_round_robin();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++) load(p, 8'(p), 1'b1, 1'b1);
        for (int c = 0; c <= 19; c++) begin
            step(1'b1);
            if (c >= 2 && c <= 17) begin
                checks++;
                if (source_valid !== ((c % 2) == 0)) begin
                    errors++;
                    $display("FAIL rr_gap c=%0d got valid=%b exp=%b", c, source_valid, (c % 2) == 0);
                end
            end
            if ((c % 2) == 1 && c <= 15) begin
                checks++;
                if (grant_id !== 2'(((c - 1) / 2) % 4)) begin
                    errors++;
                    $display("FAIL rr_grant c=%0d got=%0d exp=%0d", c, grant_id, ((c - 1) / 2) % 4);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_drain got=%0d pending exp=0", exp_q.size());
        end
    endtask

    task automatic test_single_port();
        load(2, 8'h10, 1'b0, 1'b1);
        load(2, 8'h11, 1'b0, 1'b1);
        load(2, 8'h12, 1'b1, 1'b1);
        for (int c = 0; c <= 6; c++) begin
            step(1'b1);
            case (c)
                0: begin
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("FAIL single_c0_busy got=%b exp=0", busy);
                    end
                end
                1: begin
                    checks++;
                    if ({busy, grant_id, sink_ready} !== {1'b1, 2'd2, 4'b0100}) begin
                        errors++;
                        $display("FAIL single_grant got busy=%b grant=%0d ready=%b exp 1/2/0100",
                                 busy, grant_id, sink_ready);
                    end
                end
                2, 3, 4: begin
                    checks++;
                    if ({source_valid, source_last, source_data} !== {1'b1, c == 4, 8'(8'h0E + c)}) begin
                        errors++;
                        $display("FAIL single_out c=%0d got=%b/%b/%h exp=1/%b/%h", c,
                                 source_valid, source_last, source_data, c == 4, 8'(8'h0E + c));
                    end
                    if (c == 4) begin
                        checks++;
                        if (busy !== 1'b0) begin
                            errors++;
                            $display("FAIL single_c4_busy got=%b exp=0", busy);
                        end
                    end
                end
                5: begin
                    checks++;
                    if (source_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL single_c5_valid got=%b exp=0", source_valid);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_lock();
        for (int b = 0; b < 4; b++) load(1, 8'(8'h40 + b), b == 3, 1'b1);
        for (int c = 0; c <= 9; c++) begin
            step(1'b1);
            if (c == 0) load(0, 8'hA0, 1'b1, 1'b1);
            if (c >= 1 && c <= 5) begin
                checks++;
                if (sink_ready[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_ready0 c=%0d got=%b exp=0", c, sink_ready[0]);
                end
            end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (source_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL lock_contig c=%0d got valid=%b exp=1", c, source_valid);
                end
            end
            if (c == 6) begin
                checks++;
                if ({grant_id, sink_ready} !== {2'd0, 4'b0001}) begin
                    errors++;
                    $display("FAIL lock_next got grant=%0d ready=%b exp 0/0001", grant_id, sink_ready);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lock_drain got=%0d pending exp=0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        for (int b = 0; b < 5; b++) load(3, 8'(8'h30 + b), b == 4, 1'b1);
        for (int c = 0; c <= 13; c++) begin
            step(!(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) begin
                checks++;
                if ({source_valid, source_data, sink_ready} !== {1'b1, 8'h31, 4'b0000}) begin
                    errors++;
                    $display("FAIL bp_stall c=%0d got valid=%b data=%h ready=%b exp 1/31/0000",
                             c, source_valid, source_data, sink_ready);
                end
            end
            if (c == 10) begin
                checks++;
                if ({source_valid, source_last, source_data} !== {1'b1, 1'b1, 8'h34}) begin
                    errors++;
                    $display("FAIL bp_last got=%b/%b/%h exp=1/1/34", source_valid, source_last, source_data);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain got=%0d pending exp=0", exp_q.size());
        end
    endtask

    task automatic test_stall_and_reset();
        for (int b = 0; b < 4; b++) load(1, 8'(8'h50 + b), b == 3, 1'b1);
        load(2, 8'h60, 1'b1, 1'b1);
        for (int c = 0; c <= 8; c++) begin
            step(1'b1);
            if (c == 1) begin
                checks++;
                if (grant_id !== 2'd1) begin
                    errors++;
                    $display("FAIL stall_grant got=%0d exp=1", grant_id);
                end
                hold[1] = 1'b1;
            end
            if (c >= 2 && c <= 6) begin
                checks++;
                if ({busy, grant_id, sink_ready} !== {1'b1, 2'd1, 4'b0010}) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d got busy=%b grant=%0d ready=%b exp 1/1/0010",
                             c, busy, grant_id, sink_ready);
                end
            end
            if (c == 6) hold[1] = 1'b0;
            if (c == 8) begin
                checks++;
                if ({source_valid, source_data} !== {1'b1, 8'h51}) begin
                    errors++;
                    $display("FAIL stall_resume got=%b/%h exp=1/51", source_valid, source_data);
                end
            end
        end
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({source_valid, source_data, busy, grant_id, sink_ready} !== 16'd0) begin
            errors++;
            $display("FAIL rst_async got valid=%b data=%h busy=%b grant=%0d ready=%b exp all 0",
                     source_valid, source_data, busy, grant_id, sink_ready);
        end
        flush();
        #1 sys_rst_n = 1'b1;
        load(0, 8'h70, 1'b1, 1'b1);
        load(1, 8'h71, 1'b1, 1'b1);
        for (int c = 0; c <= 6; c++) begin
            step(1'b1);
            if (c == 1) begin
                checks++;
                if ({busy, grant_id} !== {1'b1, 2'd0}) begin
                    errors++;
                    $display("FAIL rst_regrant got busy=%b grant=%0d exp 1/0", busy, grant_id);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_drain got=%0d pending exp=0", exp_q.size());
        end
    endtask

`ifdef STREAM_ARB_PKTCNT_EN
    task automatic test_pkt_count();
        int exp_cnt;
        apply_reset();
        exp_cnt = 0;
        load(0, 8'hB0, 1'b0, 1'b1);
        load(0, 8'hB1, 1'b1, 1'b1);
        load(1, 8'hB2, 1'b1, 1'b1);
        load(2, 8'hB3, 1'b0, 1'b1);
        load(2, 8'hB4, 1'b1, 1'b1);
        for (int c = 0; c <= 20; c++) begin
            step(!(c >= 3 && c <= 5));
            checks++;
            if (pkt_count !== 16'(exp_cnt)) begin
                errors++;
                $display("FAIL pktcnt_track c=%0d got=%0d exp=%0d", c, pkt_count, exp_cnt);
            end
            if (source_valid && source_ready && source_last) exp_cnt++;
        end
        checks++;
        if (pkt_count !== 16'd3) begin
            errors++;
            $display("FAIL pktcnt_three got=%0d exp=3", pkt_count);
        end
    endtask

    task automatic test_pkt_wrap();
        int acc;
        apply_reset();
        mon_en = 1'b0;
        acc    = 0;
        for (int n = 0; n < 140000 && acc < 65536; n++) begin
            if (6'(tail[0] - head[0]) < 6'd2) load(0, 8'hEE, 1'b1, 1'b0);
            step(1'b1);
            if (source_valid && source_ready && source_last) begin
                acc++;
                if (acc == 65536) begin
                    checks++;
                    if (pkt_count !== 16'hFFFF) begin
                        errors++;
                        $display("FAIL wrap_max got=%h exp=ffff", pkt_count);
                    end
                end
            end
        end
        step(1'b1);
        checks++;
        if (acc != 65536 || pkt_count !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero got count=%h packets=%0d exp 0000/65536", pkt_count, acc);
        end
        flush();
        mon_en = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single_port();
        test_lock();
        test_backpressure();
        test_stall_and_reset();
`ifdef STREAM_ARB_PKTCNT_EN
        test_pkt_count();
        test_pkt_wrap();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_packet_arbiter.md
# stream_packet_arbiter

Packet-level round-robin arbiter that shares one valid/ready/last byte stream, e.g. the input of the stream adder datapath, between NUM_PORTS requesting streams. Once a port is granted, it is locked until its `last` beat is forwarded, so packets never interleave. The output is registered, one stage, at full throughput. It sits between the packet sources and the shared stream processing datapath.

## Interface
- NUM_PORTS, 4: number of requesting sink streams, legal 2..8.
- DATA_WIDTH, 8: beat width in bits.
- sys_clk  in  1  single clock, all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- sink_valid  in  NUM_PORTS  per-port valid, bit i = port i.
- sink_last  in  NUM_PORTS  per-port end-of-packet marker.
- sink_data  in  NUM_PORTS*DATA_WIDTH  port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- sink_ready  out  NUM_PORTS  per-port ready, at most one bit high.
- source_valid  out  1  registered output valid.
- source_last  out  1  registered output last.
- source_data  out  DATA_WIDTH  registered output data.
- source_ready  in  1  downstream ready.
- grant_id  out  clog2(NUM_PORTS)  currently or last granted port.
- busy  out  1  high while in LOCKED.

## Operation
- A beat transfers on any interface when valid and ready are both high at a rising edge.
- The FSM has two states.
  - IDLE: if any sink_valid bit is high, select the first valid port scanning upward, circularly, from last_grant+1. Load grant_id, go to LOCKED, and set busy. No beat transfers in this cycle. sink_ready = 0.
  - LOCKED: sink_ready[grant_id] = (!source_valid || source_ready). All other sink_ready bits are 0.
  - A granted transfer loads the granted sink_data and sink_last into the output register and sets source_valid.
  - A granted transfer with sink_last = 1 sets last_grant = grant_id and returns to IDLE.
- Output register behaviour:
  - If source_valid && source_ready and no new beat loads, source_valid clears.
  - Data and last hold while source_valid && !source_ready.
- A granted port dropping sink_valid mid-packet is not an error. The arbiter stays LOCKED and waits indefinitely.
- Requests from other ports during LOCKED are ignored until return to IDLE.
- A one-beat packet (last on the first beat) is legal: LOCKED for a single transfer, then IDLE.
- Reset values:
  - State IDLE, busy 0, grant_id 0.
  - last_grant NUM_PORTS-1, so port 0 wins the first arbitration.
  - source_valid 0, source_last 0, source_data 0, sink_ready all 0.
- Reset asserted mid-packet clears everything asynchronously. The partial packet is abandoned with no recovery. The output beat in flight is dropped.

## Timing
- Arbitration overhead: 1 idle cycle per packet, spent in IDLE.
- Latency: sink_valid rises in IDLE at cycle 0. The grant is registered at edge 1. The first beat transfers at edge 2, and source_valid is high in cycle 2.
- Throughput: 1 beat/cycle within a packet while source_ready is held high.
- Back-to-back packets: with the same or a different port requesting, a minimum of 1 cycle passes with sink_ready all 0 between the last beat of one packet and the first beat of the next.
- Round-robin fairness: with all ports continuously requesting, the grant order is 0,1,2,...,NUM_PORTS-1,0,...
- Combinational paths: sink_ready depends on source_ready. There is no path from sink to source.

## Configuration
- STREAM_ARB_PKTCNT_EN defined:
  - Adds output pkt_count, 16 bits, the total number of packets forwarded.
  - It increments when the output beat with source_last = 1 is accepted (source_valid && source_ready && source_last).
  - It wraps from 0xFFFF to 0x0000 and resets to 0.
- Not defined: the pkt_count port and its counter are absent. All other behaviour is identical.

## Test plan
- Single port:
  - Stimulus: port 2 sends a 3-beat packet 0x10, 0x11, 0x12 (last on 0x12), with source_ready held at 1.
  - Required: grant_id = 2 and busy = 1 from cycle 1. Output 0x10/0x11/0x12 in cycles 2-4, with source_last only in cycle 4. busy = 0 in cycle 4.
- Round-robin:
  - Stimulus: all 4 ports continuously offer 1-beat packets whose data equals the port index.
  - Required: output sequence 0,1,2,3,0,1, with a 1-cycle gap between each.
- Lock:
  - Stimulus: port 1 sends a 4-beat packet while port 0 requests from cycle 1 onward.
  - Required: all 4 port-1 beats are forwarded contiguously. sink_ready[0] stays 0 until port 0 is granted in the IDLE cycle after port 1's last beat.
- Backpressure:
  - Stimulus: source_ready = 0 for cycles 3-6 during a 5-beat packet.
  - Required: source_data is stable while stalled, sink_ready[grant] = 0, and no beat is lost or duplicated.
- Mid-packet stall and reset:
  - Stimulus: the granted port drops sink_valid for 5 cycles, then resumes.
  - Required: busy stays 1 and no other port is granted.
  - Stimulus: sys_rst_n is then pulsed low mid-packet.
  - Required: source_valid = 0 immediately, state is IDLE, and the next grant goes to port 0.
- With STREAM_ARB_PKTCNT_EN:
  - Stimulus: 3 packets are forwarded, one of them delayed by backpressure on its last beat.
  - Required: pkt_count = 3, incremented only on the accepted last beats.
  - Stimulus: 65536 1-beat packets are forwarded.
  - Required: pkt_count wraps to 0.
